// File: rtl/deparser_pkg.sv
// Shared types and constants for the deparse action sequencer.
//   state_t     : sequencer FSM states
//   SZ_*        : value size codes carried on parse actions and returned value types
//   ACT_*       : bit positions inside one parse action
//   type_mask() : keep-mask for a returned 48-bit value given its size code
package deparser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUT
    } state_t;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_2B   = 2'b01;
    localparam logic [1:0] SZ_4B   = 2'b10;
    localparam logic [1:0] SZ_6B   = 2'b11;

    localparam int ACT_VLD     = 0;
    localparam int ACT_IDX_LSB = 1;
    localparam int ACT_IDX_MSB = 6;
    localparam int ACT_SZ_LSB  = 7;
    localparam int ACT_SZ_MSB  = 8;

    localparam int VAL_W = 48;

    function automatic logic [VAL_W-1:0] type_mask(input logic [1:0] val_type);
        case (val_type)
            SZ_2B:   return 48'h0000_0000_FFFF;
            SZ_4B:   return 48'h0000_FFFF_FFFF;
            SZ_6B:   return 48'hFFFF_FFFF_FFFF;
            default: return 48'h0000_0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/deparse_act_sequencer.sv
// Deparse action sequencer.
// Accepts one PHV plus its action list, replays the actions to an external
// sub_deparser one per cycle (fixed latency, invalid actions still take a
// cycle), and collects the returned values into an indexed header record.
// Ports:
//   clk, aresetn                       clock, synchronous active-low reset
//   phv_in_valid/phv_in_ready          PHV + action list handshake
//   phv_in, parse_acts_in              PHV and C_NUM_ACTS packed actions
//   parse_act_valid, parse_act         action stream to the sub_deparser
//   phv_out                            latched PHV for the sub_deparser
//   val_in_valid, val_in, val_in_type  value returned one cycle after issue
//   hdr_out_valid/hdr_out_ready        header record handshake
//   hdr_vals, hdr_types, hdr_mask      per-slot value, size type, captured flag
//   protocol_err                       one-cycle pulse on return/expect mismatch
module deparse_act_sequencer
    import deparser_pkg::*;
#(
    parameter int C_PKT_VEC_WIDTH = 2304,
    parameter int C_PARSE_ACT_LEN = 9,
    parameter int C_NUM_ACTS      = 10
) (
    input  logic                                  clk,
    input  logic                                  aresetn,
    input  logic                                  phv_in_valid,
    output logic                                  phv_in_ready,
    input  logic [C_PKT_VEC_WIDTH-1:0]            phv_in,
    input  logic [C_NUM_ACTS*C_PARSE_ACT_LEN-1:0] parse_acts_in,
    output logic                                  parse_act_valid,
    output logic [C_PARSE_ACT_LEN-1:0]            parse_act,
    output logic [C_PKT_VEC_WIDTH-1:0]            phv_out,
    input  logic                                  val_in_valid,
    input  logic [47:0]                           val_in,
    input  logic [1:0]                            val_in_type,
    output logic                                  hdr_out_valid,
    input  logic                                  hdr_out_ready,
    output logic [C_NUM_ACTS*48-1:0]              hdr_vals,
    output logic [C_NUM_ACTS*2-1:0]               hdr_types,
    output logic [C_NUM_ACTS-1:0]                 hdr_mask,
    output logic                                  protocol_err
);

    localparam int                IDX_W    = $clog2(C_NUM_ACTS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(C_NUM_ACTS - 1);

    state_t                                state_q, state_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic                                  drain_q, drain_d;
    logic                                  ready_q, ready_d;
    logic [C_PKT_VEC_WIDTH-1:0]            phv_q, phv_d;
    logic [C_NUM_ACTS*C_PARSE_ACT_LEN-1:0] acts_q, acts_d;
    logic [C_PARSE_ACT_LEN-1:0]            act_q, act_d;
    logic                                  act_vld_q, act_vld_d;
    // Tag pipe: stage 0 travels with the issued action, stage 1 lines up
    // with the value the sub_deparser returns one register later.
    logic                                  tag0_vld_q, tag0_vld_d;
    logic [IDX_W-1:0]                      tag0_idx_q, tag0_idx_d;
    logic                                  tag1_vld_q, tag1_vld_d;
    logic [IDX_W-1:0]                      tag1_idx_q, tag1_idx_d;
    logic [C_NUM_ACTS*VAL_W-1:0]           vals_q, vals_d;
    logic [C_NUM_ACTS*2-1:0]               types_q, types_d;
    logic [C_NUM_ACTS-1:0]                 mask_q, mask_d;
    logic                                  perr_q, perr_d;
    logic [C_PARSE_ACT_LEN-1:0]            cur_act;

    assign cur_act = acts_q[int'(idx_q)*C_PARSE_ACT_LEN +: C_PARSE_ACT_LEN];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        drain_d    = drain_q;
        phv_d      = phv_q;
        acts_d     = acts_q;
        act_d      = '0;
        act_vld_d  = 1'b0;
        tag0_vld_d = 1'b0;
        tag0_idx_d = '0;
        tag1_vld_d = tag0_vld_q;
        tag1_idx_d = tag0_idx_q;
        vals_d     = vals_q;
        types_d    = types_q;
        mask_d     = mask_q;

        case (state_q)
            IDLE: begin
                if (phv_in_valid && ready_q) begin
                    phv_d   = phv_in;
                    acts_d  = parse_acts_in;
                    vals_d  = '0;
                    types_d = '0;
                    mask_d  = '0;
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Every index costs one cycle whether or not it issues, so the
                // record latency never depends on the action list contents.
                act_d      = cur_act;
                act_vld_d  = cur_act[ACT_VLD];
                tag0_vld_d = cur_act[ACT_VLD];
                tag0_idx_d = idx_q;
                if (idx_q == LAST_IDX) begin
                    drain_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_d = OUT;
                end else begin
                    drain_d = 1'b1;
                end
            end
            OUT: begin
                if (hdr_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int k = 0; k < C_NUM_ACTS; k++) begin
            if (tag1_vld_q && val_in_valid && (tag1_idx_q == IDX_W'(k))) begin
                vals_d[k*VAL_W +: VAL_W] = val_in & type_mask(val_in_type);
                types_d[k*2 +: 2]        = val_in_type;
                mask_d[k]                = 1'b1;
            end
        end

        perr_d  = tag1_vld_q ^ val_in_valid;
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            drain_q    <= 1'b0;
            ready_q    <= 1'b0;
            phv_q      <= '0;
            acts_q     <= '0;
            act_q      <= '0;
            act_vld_q  <= 1'b0;
            tag0_vld_q <= 1'b0;
            tag0_idx_q <= '0;
            tag1_vld_q <= 1'b0;
            tag1_idx_q <= '0;
            vals_q     <= '0;
            types_q    <= '0;
            mask_q     <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            drain_q    <= drain_d;
            ready_q    <= ready_d;
            phv_q      <= phv_d;
            acts_q     <= acts_d;
            act_q      <= act_d;
            act_vld_q  <= act_vld_d;
            tag0_vld_q <= tag0_vld_d;
            tag0_idx_q <= tag0_idx_d;
            tag1_vld_q <= tag1_vld_d;
            tag1_idx_q <= tag1_idx_d;
            vals_q     <= vals_d;
            types_q    <= types_d;
            mask_q     <= mask_d;
            perr_q     <= perr_d;
        end
    end

    assign phv_in_ready    = ready_q;
    assign parse_act_valid = act_vld_q;
    assign parse_act       = act_q;
    assign phv_out         = phv_q;
    assign hdr_out_valid   = (state_q == OUT);
    assign hdr_vals        = vals_q;
    assign hdr_types       = types_q;
    assign hdr_mask        = mask_q;
    assign protocol_err    = perr_q;

endmodule

// File: tb/tb_deparse_act_sequencer.sv
// Directed bench for deparse_act_sequencer with a one-register sub_deparser
// model. Cycle numbers are counted in clock periods; outputs are sampled on
// the falling edge, so "cycle T" is the cycle in which valid&ready is seen.
module tb_deparse_act_sequencer;
    localparam int W    = 2304;
    localparam int LEN  = 9;
    localparam int NACT = 10;

    logic                 clk = 1'b0;
    logic                 aresetn = 1'b0;
    logic                 phv_in_valid = 1'b0;
    logic                 phv_in_ready;
    logic [W-1:0]         phv_in = '0;
    logic [NACT*LEN-1:0]  parse_acts_in = '0;
    logic                 parse_act_valid;
    logic [LEN-1:0]       parse_act;
    logic [W-1:0]         phv_out;
    logic                 val_in_valid;
    logic [47:0]          val_in;
    logic [1:0]           val_in_type;
    logic                 hdr_out_valid;
    logic                 hdr_out_ready = 1'b0;
    logic [NACT*48-1:0]   hdr_vals;
    logic [NACT*2-1:0]    hdr_types;
    logic [NACT-1:0]      hdr_mask;
    logic                 protocol_err;

    logic                 sd_vld = 1'b0;
    logic [47:0]          sd_val = '0;
    logic [1:0]           sd_type = '0;
    logic                 force_vld = 1'b0;

    int cyc = 0;
    int issue_cnt = 0;
    int last_issue_cyc = 0;
    int perr_cnt = 0;
    int last_perr_cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    deparse_act_sequencer dut (
        .clk(clk), .aresetn(aresetn),
        .phv_in_valid(phv_in_valid), .phv_in_ready(phv_in_ready),
        .phv_in(phv_in), .parse_acts_in(parse_acts_in),
        .parse_act_valid(parse_act_valid), .parse_act(parse_act),
        .phv_out(phv_out),
        .val_in_valid(val_in_valid), .val_in(val_in), .val_in_type(val_in_type),
        .hdr_out_valid(hdr_out_valid), .hdr_out_ready(hdr_out_ready),
        .hdr_vals(hdr_vals), .hdr_types(hdr_types), .hdr_mask(hdr_mask),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // sub_deparser model: one register; upper 16 bits deliberately stale.
    always @(posedge clk) begin
        sd_vld  <= parse_act_valid;
        sd_type <= parse_act[8:7];
        sd_val  <= {16'hDEAD, phv_out[int'(parse_act[6:1])*32 +: 32]};
    end
    assign val_in_valid = sd_vld | force_vld;
    assign val_in       = sd_val;
    assign val_in_type  = sd_type;

    always @(negedge clk) begin
        if (parse_act_valid) begin
            issue_cnt++;
            last_issue_cyc = cyc;
        end
        if (protocol_err) begin
            perr_cnt++;
            last_perr_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LEN-1:0] mk_act(input logic [1:0] sz, input int idx);
        return {sz, 6'(idx), 1'b1};
    endfunction

    // Offer a PHV and return the handshake cycle.
    task automatic start(input string tag, input logic [W-1:0] p, input logic [NACT*LEN-1:0] a,
                         output int t);
        int g;
        g = 0;
        @(negedge clk);
        phv_in = p;
        parse_acts_in = a;
        phv_in_valid = 1'b1;
        while (!phv_in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_accept"}, 512'(phv_in_ready), 512'(1));
        t = cyc;
        @(negedge clk);
        phv_in_valid = 1'b0;
    endtask

    task automatic wait_hdr(input string tag, input int t);
        int g;
        g = 0;
        while (!hdr_out_valid && g < 40) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_latency"}, 512'(cyc - t), 512'(13));
    endtask

    task automatic release_hdr(input string tag);
        hdr_out_ready = 1'b1;
        @(negedge clk);
        hdr_out_ready = 1'b0;
        check({tag, "_ready_after"}, 512'(phv_in_ready), 512'(1));
        check({tag, "_valid_after"}, 512'(hdr_out_valid), 512'(0));
    endtask

    initial begin
        logic [W-1:0]        phv_a, phv_b;
        logic [NACT*LEN-1:0] acts;
        logic [NACT*48-1:0]  ev;
        logic [NACT*2-1:0]   et;
        int t, t2, ic0, pc0;

        phv_a = '0;
        for (int i = 0; i < 64; i++) phv_a[i*32 +: 32] = 32'hA000_0000 | 32'(i);
        phv_b = phv_a;
        phv_b[5*32 +: 32] = 32'h1234_5678;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 512'(phv_in_ready), 512'(0));
        check("rst_hdr_valid", 512'(hdr_out_valid), 512'(0));
        check("rst_act_valid", 512'(parse_act_valid), 512'(0));
        check("rst_mask", 512'(hdr_mask), 512'(0));
        check("rst_perr", 512'(protocol_err), 512'(0));
        aresetn = 1'b1;
        @(negedge clk);
        check("idle_ready", 512'(phv_in_ready), 512'(1));

        // 1: four 4-byte actions
        acts = '0;
        for (int k = 0; k < 4; k++) acts[k*LEN +: LEN] = mk_act(2'b10, k);
        ic0 = issue_cnt; pc0 = perr_cnt;
        start("t1", phv_a, acts, t);
        wait_hdr("t1", t);
        ev = '0; et = '0;
        for (int k = 0; k < 4; k++) begin
            ev[k*48 +: 48] = 48'h0000_A000_0000 | 48'(k);
            et[k*2 +: 2] = 2'b10;
        end
        check("t1_mask", 512'(hdr_mask), 512'(10'h00F));
        check("t1_vals", 512'(hdr_vals), 512'(ev));
        check("t1_types", 512'(hdr_types), 512'(et));
        check("t1_issues", 512'(issue_cnt - ic0), 512'(4));
        check("t1_last_issue", 512'(last_issue_cyc - t), 512'(5));
        check("t1_perr", 512'(perr_cnt - pc0), 512'(0));
        release_hdr("t1");

        // 2: all actions invalid
        ic0 = issue_cnt;
        start("t2", phv_a, '0, t);
        wait_hdr("t2", t);
        check("t2_mask", 512'(hdr_mask), 512'(0));
        check("t2_vals", 512'(hdr_vals), 512'(0));
        check("t2_issues", 512'(issue_cnt - ic0), 512'(0));
        release_hdr("t2");

        // 3: emitter stalls 20 cycles while a second PHV waits (test 6 content)
        acts = '0;
        acts[0 +: LEN] = mk_act(2'b10, 7);
        start("t3", phv_a, acts, t);
        wait_hdr("t3", t);
        phv_in = phv_b;
        acts = '0;
        acts[0 +: LEN] = mk_act(2'b01, 5);
        acts[LEN +: LEN] = mk_act(2'b11, 2);
        parse_acts_in = acts;
        phv_in_valid = 1'b1;
        repeat (20) @(negedge clk);
        check("t3_hold_valid", 512'(hdr_out_valid), 512'(1));
        check("t3_hold_ready", 512'(phv_in_ready), 512'(0));
        check("t3_hold_mask", 512'(hdr_mask), 512'(1));
        check("t3_hold_slot0", 512'(hdr_vals[47:0]), 512'(48'h0000_A000_0007));
        check("t3_hold_phv", 512'(phv_out[7*32 +: 32]), 512'(32'hA000_0007));
        hdr_out_ready = 1'b1;
        @(negedge clk);
        hdr_out_ready = 1'b0;
        check("t3_ready_next", 512'(phv_in_ready), 512'(1));
        check("t3_valid_drop", 512'(hdr_out_valid), 512'(0));
        t2 = cyc;
        @(negedge clk);
        phv_in_valid = 1'b0;
        check("t3_second_busy", 512'(phv_in_ready), 512'(0));

        // 6: 2-byte value with stale upper bits, plus a 6-byte value
        wait_hdr("t6", t2);
        ev = '0; et = '0;
        ev[0 +: 48] = 48'h0000_0000_5678; et[0 +: 2] = 2'b01;
        ev[48 +: 48] = 48'hDEAD_A000_0002; et[2 +: 2] = 2'b11;
        check("t6_mask", 512'(hdr_mask), 512'(10'h003));
        check("t6_vals", 512'(hdr_vals), 512'(ev));
        check("t6_types", 512'(hdr_types), 512'(et));
        release_hdr("t6");

        // 4: spurious return while nothing is in flight
        pc0 = perr_cnt;
        start("t4", phv_a, '0, t);
        while (cyc < t + 4) @(negedge clk);
        force_vld = 1'b1;
        @(negedge clk);
        force_vld = 1'b0;
        wait_hdr("t4", t);
        check("t4_perr_count", 512'(perr_cnt - pc0), 512'(1));
        check("t4_perr_cycle", 512'(last_perr_cyc - t), 512'(5));
        check("t4_mask", 512'(hdr_mask), 512'(0));
        release_hdr("t4");

        // 5: reset mid-operation, then a fresh PHV
        acts = '0;
        for (int k = 0; k < 4; k++) acts[k*LEN +: LEN] = mk_act(2'b10, k);
        start("t5", phv_a, acts, t);
        while (cyc < t + 5) @(negedge clk);
        aresetn = 1'b0;
        @(negedge clk);
        check("t5_act_valid", 512'(parse_act_valid), 512'(0));
        check("t5_ready", 512'(phv_in_ready), 512'(0));
        check("t5_mask", 512'(hdr_mask), 512'(0));
        check("t5_phv_out", 512'(phv_out[63:0]), 512'(0));
        check("t5_hdr_valid", 512'(hdr_out_valid), 512'(0));
        @(negedge clk);
        aresetn = 1'b1;
        pc0 = perr_cnt;
        acts = '0;
        acts[0 +: LEN] = mk_act(2'b10, 9);
        start("t5b", phv_a, acts, t);
        wait_hdr("t5b", t);
        check("t5b_mask", 512'(hdr_mask), 512'(1));
        check("t5b_slot0", 512'(hdr_vals[47:0]), 512'(48'h0000_A000_0009));
        check("t5b_perr", 512'(perr_cnt - pc0), 512'(0));
        release_hdr("t5b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
